// File: rtl/pipe_ctrl_tags_if.sv
// pipe_ctrl_tags_if: hazard-unit <-> control-tag chain signals
interface pipe_ctrl_tags_if #(parameter int CNT_W = 32);
  logic IMRead, FDWrite, DEFlush;
  logic [4:0] RA0_D, RA1_D, WA_D;
  logic RS1Used_D, RS2Used_D, WEN_D, Load_D;
  logic Valid_D;
  logic [4:0] RA0_E, RA1_E;
  logic RS1Used_E, RS2Used_E;
  logic [4:0] WA_E, WA_M1, WA_M2, WA_W;
  logic WEN_E, WEN_M1, WEN_M2, WEN_W;
  logic Load_E, Load_M1, Valid_W;
  logic [CNT_W-1:0] StallCnt, FlushCnt, RetireCnt;
  logic DEADLOCK;
  modport master (
    output IMRead, FDWrite, DEFlush, RA0_D, RA1_D, WA_D, RS1Used_D, RS2Used_D, WEN_D, Load_D,
    input Valid_D, RA0_E, RA1_E, RS1Used_E, RS2Used_E, WA_E, WA_M1, WA_M2, WA_W,
    input WEN_E, WEN_M1, WEN_M2, WEN_W, Load_E, Load_M1, Valid_W,
    input StallCnt, FlushCnt, RetireCnt, DEADLOCK
  );
  modport slave (
    input IMRead, FDWrite, DEFlush, RA0_D, RA1_D, WA_D, RS1Used_D, RS2Used_D, WEN_D, Load_D,
    output Valid_D, RA0_E, RA1_E, RS1Used_E, RS2Used_E, WA_E, WA_M1, WA_M2, WA_W,
    output WEN_E, WEN_M1, WEN_M2, WEN_W, Load_E, Load_M1, Valid_W,
    output StallCnt, FlushCnt, RetireCnt, DEADLOCK
  );
endinterface

// File: rtl/pipe_ctrl_tags.sv
// pipe_ctrl_tags: hazard tag chain D->E->M1->M2->W with validity, event counters and stall deadlock flag
module pipe_ctrl_tags #(
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 8
) (
  input  logic           CLK,
  input  logic           RST,
  pipe_ctrl_tags_if.slave pc
);
  typedef struct packed {
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic       rs1;
    logic       rs2;
    logic [4:0] wa;
    logic       wen;
    logic       load;
    logic       vld;
  } etag_t;
  localparam etag_t BUB_E = '{ra0: 5'd0, ra1: 5'd0, rs1: 1'b0, rs2: 1'b0,
                              wa: 5'd0, wen: 1'b1, load: 1'b0, vld: 1'b0};
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction
  etag_t            e_q, e_d;
  logic             valid_d_q, valid_d_d;
  logic [4:0]       wa_m1_q, wa_m2_q, wa_w_q;
  logic             wen_m1_q, wen_m2_q, wen_w_q;
  logic             load_m1_q, vld_m1_q, vld_m2_q, vld_w_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, retire_cnt_q, retire_cnt_d;
  logic [7:0]       run_q, run_d;
  logic             deadlock_q, deadlock_d;
  logic             stall, bubble;
  always_comb begin
    stall        = !pc.FDWrite && pc.DEFlush;
    bubble       = pc.DEFlush || !valid_d_q;
    valid_d_d    = pc.FDWrite ? pc.IMRead : valid_d_q;
    e_d          = bubble ? BUB_E : '{ra0: pc.RA0_D, ra1: pc.RA1_D, rs1: pc.RS1Used_D,
                                      rs2: pc.RS2Used_D, wa: pc.WA_D, wen: pc.WEN_D,
                                      load: pc.Load_D, vld: 1'b1};
    stall_cnt_d  = sat_inc(stall_cnt_q, stall);
    flush_cnt_d  = sat_inc(flush_cnt_q, bubble);
    retire_cnt_d = sat_inc(retire_cnt_q, vld_w_q);
    run_d        = stall ? run_q + 8'(run_q != 8'hFF) : 8'd0;
    // compares the next run length so DEADLOCK shows on the edge that completes the (STALL_MAX+1)th stall
    deadlock_d   = deadlock_q || (int'(run_d) > STALL_MAX);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_d_q    <= 1'b0;
      e_q          <= BUB_E;
      wa_m1_q      <= 5'd0;
      wa_m2_q      <= 5'd0;
      wa_w_q       <= 5'd0;
      wen_m1_q     <= 1'b1;
      wen_m2_q     <= 1'b1;
      wen_w_q      <= 1'b1;
      load_m1_q    <= 1'b0;
      vld_m1_q     <= 1'b0;
      vld_m2_q     <= 1'b0;
      vld_w_q      <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
      run_q        <= 8'd0;
      deadlock_q   <= 1'b0;
    end else begin
      valid_d_q    <= valid_d_d;
      e_q          <= e_d;
      wa_m1_q      <= e_q.wa;
      wa_m2_q      <= wa_m1_q;
      wa_w_q       <= wa_m2_q;
      wen_m1_q     <= e_q.wen;
      wen_m2_q     <= wen_m1_q;
      wen_w_q      <= wen_m2_q;
      load_m1_q    <= e_q.load;
      vld_m1_q     <= e_q.vld;
      vld_m2_q     <= vld_m1_q;
      vld_w_q      <= vld_m2_q;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      run_q        <= run_d;
      deadlock_q   <= deadlock_d;
    end
  end
  assign pc.Valid_D   = valid_d_q;
  assign pc.RA0_E     = e_q.ra0;
  assign pc.RA1_E     = e_q.ra1;
  assign pc.RS1Used_E = e_q.rs1;
  assign pc.RS2Used_E = e_q.rs2;
  assign pc.WA_E      = e_q.wa;
  assign pc.WEN_E     = e_q.wen;
  assign pc.Load_E    = e_q.load;
  assign pc.WA_M1     = wa_m1_q;
  assign pc.WEN_M1    = wen_m1_q;
  assign pc.Load_M1   = load_m1_q;
  assign pc.WA_M2     = wa_m2_q;
  assign pc.WEN_M2    = wen_m2_q;
  assign pc.WA_W      = wa_w_q;
  assign pc.WEN_W     = wen_w_q;
  assign pc.Valid_W   = vld_w_q;
  assign pc.StallCnt  = stall_cnt_q;
  assign pc.FlushCnt  = flush_cnt_q;
  assign pc.RetireCnt = retire_cnt_q;
  assign pc.DEADLOCK  = deadlock_q;
endmodule

// File: tb/tb_pipe_ctrl_tags.sv
// tb_pipe_ctrl_tags: vector table, corner sequences and random traffic against a queue-based pipeline model
module tb_pipe_ctrl_tags;
  localparam int CW = 5;
  localparam int SM = 8;
  localparam int CMAX = 2 ** CW - 1;
  typedef struct packed {
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic       rs1;
    logic       rs2;
    logic [4:0] wa;
    logic       wen;
    logic       ld;
    logic       vld;
  } tag_t;
  localparam tag_t BUB = '{ra0: 5'd0, ra1: 5'd0, rs1: 1'b0, rs2: 1'b0,
                           wa: 5'd0, wen: 1'b1, ld: 1'b0, vld: 1'b0};
  typedef struct {
    int rst, imr, fdw, dfl, wa, wen, ld, ra0;
    int vd, wa_e, wen_e, ld_e, ra0_e, wa_w, wen_w, vw, sc, fc, rc;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_ctrl_tags_if #(.CNT_W(CW)) pc ();
  pipe_ctrl_tags #(.CNT_W(CW), .STALL_MAX(SM)) dut (.CLK(clk), .RST(rst), .pc(pc));
  int   n_run = 0;
  int   n_fail = 0;
  tag_t pipe[$];
  logic m_vd = 1'b0;
  logic m_dl = 1'b0;
  int   m_sc, m_fc, m_rc, m_run;
  bit   armed = 0;
  vec_t tv[16];
  vec_t v;
  int   burst = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int sat(input int x);
    return x > CMAX ? CMAX : x;
  endfunction
  task automatic model_edge();
    tag_t e;
    bit   bub, stl;
    if (rst) begin
      pipe = '{BUB, BUB, BUB, BUB};
      m_vd = 1'b0; m_dl = 1'b0;
      m_sc = 0; m_fc = 0; m_rc = 0; m_run = 0;
      armed = 1;
    end else if (armed) begin
      bub = pc.DEFlush || !m_vd;
      stl = !pc.FDWrite && pc.DEFlush;
      e = bub ? BUB : '{ra0: pc.RA0_D, ra1: pc.RA1_D, rs1: pc.RS1Used_D, rs2: pc.RS2Used_D,
                        wa: pc.WA_D, wen: pc.WEN_D, ld: pc.Load_D, vld: 1'b1};
      m_sc = sat(m_sc + int'(stl));
      m_fc = sat(m_fc + int'(bub));
      m_rc = sat(m_rc + int'(pipe[3].vld));
      m_run = stl ? (m_run < 255 ? m_run + 1 : 255) : 0;
      if (m_run > SM) m_dl = 1'b1;
      void'(pipe.pop_back());
      pipe.push_front(e);
      if (pc.FDWrite) m_vd = pc.IMRead;
    end
  endtask
  task automatic mchk();
    chk("valid", {pc.Valid_D, pc.Valid_W}, {m_vd, pipe[3].vld});
    chk("tagE", {pc.RA0_E, pc.RA1_E, pc.RS1Used_E, pc.RS2Used_E, pc.WA_E, pc.WEN_E, pc.Load_E},
        {pipe[0].ra0, pipe[0].ra1, pipe[0].rs1, pipe[0].rs2, pipe[0].wa, pipe[0].wen, pipe[0].ld});
    chk("tagM1", {pc.WA_M1, pc.WEN_M1, pc.Load_M1}, {pipe[1].wa, pipe[1].wen, pipe[1].ld});
    chk("tagM2", {pc.WA_M2, pc.WEN_M2}, {pipe[2].wa, pipe[2].wen});
    chk("tagW", {pc.WA_W, pc.WEN_W}, {pipe[3].wa, pipe[3].wen});
    chk("StallCnt", 64'(pc.StallCnt), 64'(m_sc));
    chk("FlushCnt", 64'(pc.FlushCnt), 64'(m_fc));
    chk("RetireCnt", 64'(pc.RetireCnt), 64'(m_rc));
    chk("DEADLOCK", 64'(pc.DEADLOCK), 64'(m_dl));
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (armed) mchk();
  endtask
  task automatic drive(input bit r, input bit imr, input bit fdw, input bit dfl);
    rst = r; pc.IMRead = imr; pc.FDWrite = fdw; pc.DEFlush = dfl;
  endtask
  task automatic rand_tag();
    pc.RA0_D = 5'($urandom); pc.RA1_D = 5'($urandom); pc.WA_D = 5'($urandom);
    pc.RS1Used_D = 1'($urandom); pc.RS2Used_D = 1'($urandom);
    pc.WEN_D = 1'($urandom); pc.Load_D = 1'($urandom);
  endtask
  initial begin
    int r;
    drive(1, 0, 0, 0);
    pc.RA0_D = 0; pc.RA1_D = 0; pc.WA_D = 0;
    pc.RS1Used_D = 0; pc.RS2Used_D = 0; pc.WEN_D = 0; pc.Load_D = 0;
    //        rst imr fdw dfl wa wen ld ra0 | vd wa_e wen_e ld_e ra0_e wa_w wen_w vw sc fc rc
    tv = '{
      '{1, 1, 1, 0,  5, 0, 1, 7,   0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0},
      '{1, 0, 0, 1,  3, 0, 1, 2,   0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0},
      '{0, 1, 1, 0,  5, 0, 0, 7,   1,  0, 1, 0, 0,  0, 1, 0, 0, 1, 0},
      '{0, 1, 1, 0,  5, 0, 0, 7,   1,  5, 0, 0, 7,  0, 1, 0, 0, 1, 0},
      '{0, 1, 1, 0,  3, 0, 1, 1,   1,  3, 0, 1, 1,  0, 1, 0, 0, 1, 0},
      '{0, 1, 0, 1,  6, 0, 0, 3,   1,  0, 1, 0, 0,  0, 1, 0, 1, 2, 0},
      '{0, 1, 0, 1,  6, 0, 0, 3,   1,  0, 1, 0, 0,  5, 0, 1, 2, 3, 0},
      '{0, 1, 1, 0,  6, 0, 0, 3,   1,  6, 0, 0, 3,  3, 0, 1, 2, 3, 1},
      '{0, 0, 1, 0,  9, 0, 0, 2,   0,  9, 0, 0, 2,  0, 1, 0, 2, 3, 2},
      '{0, 1, 1, 0, 12, 0, 0, 0,   1,  0, 1, 0, 0,  0, 1, 0, 2, 4, 2},
      '{0, 1, 1, 0, 10, 1, 0, 4,   1, 10, 1, 0, 4,  6, 0, 1, 2, 4, 2},
      '{0, 0, 1, 0, 11, 0, 0, 0,   0, 11, 0, 0, 0,  9, 0, 1, 2, 4, 3},
      '{0, 0, 1, 0,  0, 0, 0, 0,   0,  0, 1, 0, 0,  0, 1, 0, 2, 5, 4},
      '{0, 1, 1, 1,  0, 0, 0, 0,   1,  0, 1, 0, 0, 10, 1, 1, 2, 6, 4},
      '{0, 1, 1, 0, 13, 0, 0, 5,   1, 13, 0, 0, 5, 11, 0, 1, 2, 6, 5},
      '{1, 1, 1, 0, 13, 0, 0, 5,   0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0}
    };
    for (int i = 0; i < 16; i++) begin
      v = tv[i];
      drive(1'(v.rst), 1'(v.imr), 1'(v.fdw), 1'(v.dfl));
      pc.WA_D = 5'(v.wa); pc.WEN_D = 1'(v.wen); pc.Load_D = 1'(v.ld); pc.RA0_D = 5'(v.ra0);
      step();
      chk($sformatf("vec%0d", i),
          {pc.Valid_D, pc.WA_E, pc.WEN_E, pc.Load_E, pc.RA0_E, pc.WA_W, pc.WEN_W, pc.Valid_W,
           pc.StallCnt, pc.FlushCnt, pc.RetireCnt},
          {1'(v.vd), 5'(v.wa_e), 1'(v.wen_e), 1'(v.ld_e), 5'(v.ra0_e), 5'(v.wa_w), 1'(v.wen_w),
           1'(v.vw), CW'(v.sc), CW'(v.fc), CW'(v.rc)});
    end
    // deadlock: nine back-to-back stalls, sticky afterwards, cleared only by reset
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) chk("dl_before", 64'(pc.DEADLOCK), 64'd0);
      if (k == 9) chk("dl_set", 64'(pc.DEADLOCK), 64'd1);
    end
    chk("dl_stallcnt", 64'(pc.StallCnt), 64'd9);
    drive(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) step();
    chk("dl_sticky", 64'(pc.DEADLOCK), 64'd1);
    drive(1, 1, 1, 0); step();
    chk("dl_reset", 64'(pc.DEADLOCK), 64'd0);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step();
    drive(0, 1, 1, 0); step();
    drive(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step();
    chk("dl_broken_run", 64'(pc.DEADLOCK), 64'd0);
    // mid-flight reset with four valid instructions in E..W
    drive(1, 0, 0, 0); step();
    drive(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      rand_tag();
      step();
    end
    chk("mf_full", {pc.Valid_W, pc.Valid_D}, 2'b11);
    drive(1, 1, 1, 0); step();
    chk("mf_reset", {pc.Valid_W, pc.WEN_W, pc.WEN_M2, pc.WEN_M1, pc.WEN_E, pc.WA_M2, pc.RetireCnt},
        {1'b0, 4'hF, 5'd0, CW'(0)});
    // randomized traffic, including occasional long stall bursts
    for (int c = 0; c < 800; c++) begin
      rand_tag();
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(6, 14);
      r = $urandom_range(0, 9);
      if (burst > 0) begin
        burst--;
        drive(0, 1'($urandom), 0, 1);
      end else if ($urandom_range(0, 49) == 0) begin
        drive(1, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(0, $urandom_range(0, 3) != 0, !(r < 2 || r == 3), r < 3);
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
